pulse_xfer_scheduler: RTL and testbench
=======================================

// Module: pulse_xfer_scheduler
// PURPOSE
// - Fast-clock-domain scheduler sharing one fast->slow pulse-transfer channel among N_REQ requesters.
// - Counts single-cycle request pulses per requester; round-robin picks one pending request.
// - Drives edge_out high for RATIO fast cycles, aligned to the slow-clock phase, so the slow domain samples it reliably.
// - Enforces a RATIO-cycle low gap between transfers so consecutive edges stay distinct.
// PARAMETERS
// - N_REQ  4  number of requesters (>=2)
// - RATIO  2  fast cycles per slow cycle (>=2); sets edge_out high width and gap width
// - CNT_W  4  width of each per-requester pending counter (saturating)
// PORTS
// - clk          in   1                  fast clock
// - rst          in   1                  async active-high reset
// - en           in   1                  1 = new transfers may start
// - req_pulse    in   N_REQ              1-cycle request pulses, one bit per requester
// - ovf_clr      in   N_REQ              per-requester clear of sticky overflow flag
// - edge_out     out  1                  stretched pulse to the slow domain
// - grant_id     out  $clog2(N_REQ)      requester being served; valid while busy
// - busy         out  1                  high in ISSUE and GAP
// - slow_phase   out  $clog2(RATIO)      free-running phase counter 0..RATIO-1
// - pending_any  out  1                  OR of all counters != 0
// - ovf          out  N_REQ              sticky: pulse arrived while counter at max
// BEHAVIOUR
// - Reset (async, rst=1): counters=0, ovf=0, state=IDLE, edge_out=0, busy=0, grant_id=0,
//   slow_phase=0, RR pointer=0. Outputs are registered.
// - slow_phase increments every cycle and wraps RATIO-1 -> 0; it is never stalled by en.
// - Counter i per cycle: +1 on req_pulse[i], -1 when requester i is granted; both together -> unchanged.
//   At 2^CNT_W-1 with pulse and no grant: holds, ovf[i] <= 1.
//   ovf_clr[i] clears ovf[i]; a simultaneous set wins.
// - FSM states: IDLE, ISSUE, GAP.
//   * IDLE -> ISSUE when en=1 && slow_phase==RATIO-1 && any counter!=0.
//     The arbiter grants on that cycle: grant_id latched, that counter decrements, RR pointer -> grant+1 mod N_REQ.
//     edge_out and busy rise on the next cycle (slow_phase==0).
//   * ISSUE: edge_out=1 for exactly RATIO cycles, then -> GAP.
//   * GAP: edge_out=0, busy=1 for RATIO cycles, then -> IDLE.
//     Earliest next grant is the GAP exit cycle if phase==RATIO-1 (always true since widths are RATIO).
// - Back-to-back throughput: one transfer per 2*RATIO cycles.
// - Latency: pulse at phase RATIO-1 with counter 0 and IDLE counts in the same cycle. It is eligible
//   next at the following phase RATIO-1, so edge_out rises RATIO+1 cycles after the pulse.
// - Arbitration: among counters!=0, pick the first index at or after the RR pointer, wrapping.
//   A counter is sampled before this cycle's increment.
// - en=0: a transfer in ISSUE/GAP completes normally; no new grant. Counters still accumulate.
// - rst asserted mid-ISSUE: edge_out drops immediately (async), all pending counts are lost.
// - grant_id holds its last value in IDLE.
// STRUCTURE
// - Package pulse_sched_pkg: state enum {IDLE, ISSUE, GAP}; helper localparam
//   function for id width; no other shared types.
// - Sub-module pulse_rr_arbiter (N_REQ): inputs req vector, pointer, grant_en;
//   outputs gnt_valid, gnt_id. It is purely combinational; the pointer register lives in the top.
// - The top holds the phase counter, pending counters, ovf flags, FSM and the width counter (reused for ISSUE/GAP).
// TESTING
// - Single pulse: RATIO=2, req_pulse=0001 at phase 1 -> edge_out high for cycles t+3..t+4;
//   grant_id=0; counter back to 0.
// - Fairness: req_pulse=1111 once -> edge_out trains of 2 high/2 low; grant_id 0,1,2,3 in order;
//   pending_any falls after the 4th grant.
// - Saturation: CNT_W=2, 5 pulses on req 2 with en=0 -> cnt=3, ovf[2]=1.
//   Enable -> exactly 3 edges; ovf_clr[2] clears the flag.
// - Simultaneous: pulse on req 1 in its own grant cycle -> counter unchanged; second edge follows after the gap.
// - en drop mid-ISSUE: en=0 at second ISSUE cycle -> current edge completes (2 cycles high), no further edges while en=0.
// - Async reset mid-ISSUE: rst pulse between clk edges -> edge_out, busy, counters to 0 immediately;
//   resumes cleanly after release.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared types for the fast->slow pulse-transfer scheduler.
// Holds the FSM state encoding and the index-width helper.
package pulse_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP
   } state_e;

   // Width needed to index n items, never narrower than one bit.
   function automatic int unsigned id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pulse_rr_arbiter.sv
// Combinational round-robin arbiter. It picks the first requesting index
// at or after ptr_i, wrapping around; the pointer register lives in the caller.
module pulse_rr_arbiter
   import pulse_sched_pkg::*;
#(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]        req_i,
   input  logic [id_w(N_REQ)-1:0]  ptr_i,
   input  logic                    grant_en_i,
   output logic                    gnt_valid_o,
   output logic [id_w(N_REQ)-1:0]  gnt_id_o
);

   localparam int unsigned IDW = id_w(N_REQ);

   logic           found;
   logic [IDW-1:0] idx;

   always_comb begin
      found    = 1'b0;
      idx      = '0;
      gnt_id_o = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = IDW'((32'(ptr_i) + k) % N_REQ);
         if (!found && req_i[idx]) begin
            found    = 1'b1;
            gnt_id_o = idx;
         end
      end
      gnt_valid_o = found && grant_en_i;
   end

endmodule

// File: rtl/pulse_xfer_scheduler.sv
// Shares one fast->slow pulse channel among N_REQ requesters: counts request
// pulses, grants round-robin, and issues phase-aligned RATIO-wide pulses with gaps.
module pulse_xfer_scheduler
   import pulse_sched_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned RATIO = 2,
   parameter int unsigned CNT_W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [N_REQ-1:0]        req_pulse,
   input  logic [N_REQ-1:0]        ovf_clr,
   output logic                    edge_out,
   output logic [id_w(N_REQ)-1:0]  grant_id,
   output logic                    busy,
   output logic [id_w(RATIO)-1:0]  slow_phase,
   output logic                    pending_any,
   output logic [N_REQ-1:0]        ovf
);

   localparam int unsigned      IDW     = id_w(N_REQ);
   localparam int unsigned      PHW     = id_w(RATIO);
   localparam logic [PHW-1:0]   PH_LAST = PHW'(RATIO - 1);
   localparam logic [IDW-1:0]   ID_LAST = IDW'(N_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [PHW-1:0]   phase_q, phase_d;
   logic [PHW-1:0]   wcnt_q, wcnt_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q [N_REQ];
   logic [CNT_W-1:0] cnt_d [N_REQ];
   logic [N_REQ-1:0] ovf_q, ovf_d;
   logic             edge_q, busy_q;

   logic [N_REQ-1:0] nz;
   logic             grant_window;
   logic             fire;
   logic [IDW-1:0]   gnt_id;

   // A grant may only land on the last phase slot, either from IDLE or on the
   // final GAP cycle, so back-to-back transfers stay one per 2*RATIO cycles.
   assign grant_window = en && (phase_q == PH_LAST) &&
                         ((state_q == IDLE) || ((state_q == GAP) && (wcnt_q == PH_LAST)));

   pulse_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req_i       (nz),
      .ptr_i       (ptr_q),
      .grant_en_i  (grant_window),
      .gnt_valid_o (fire),
      .gnt_id_o    (gnt_id)
   );

   always_comb begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         nz[i] = (cnt_q[i] != '0);
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (fire) begin
               state_d = ISSUE;
               wcnt_d  = '0;
            end
         end
         ISSUE: begin
            if (wcnt_q == PH_LAST) begin
               state_d = GAP;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         GAP: begin
            if (wcnt_q == PH_LAST) begin
               state_d = fire ? ISSUE : IDLE;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            wcnt_d  = '0;
         end
      endcase
      if (fire) begin
         grant_d = gnt_id;
         ptr_d   = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cnt_d[i] = cnt_q[i];
         ovf_d[i] = ovf_q[i] & ~ovf_clr[i];
         if (req_pulse[i] && !(fire && (gnt_id == IDW'(i)))) begin
            if (cnt_q[i] == CNT_MAX) begin
               ovf_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else if (!req_pulse[i] && fire && (gnt_id == IDW'(i))) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         wcnt_q  <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '{default: '0};
         ovf_q   <= '0;
         edge_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         wcnt_q  <= wcnt_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         edge_q  <= (state_d == ISSUE);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign edge_out    = edge_q;
   assign busy        = busy_q;
   assign grant_id    = grant_q;
   assign slow_phase  = phase_q;
   assign pending_any = |nz;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_pulse_xfer_scheduler.sv
// Scoreboard bench for pulse_xfer_scheduler: stimulus queues expected transfers,
// a monitor pops one on every rising edge_out and checks id, timing and widths.
module tb_pulse_xfer_scheduler;

   localparam int R = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] req_pulse;
   logic [3:0] ovf_clr;
   logic       edge_out;
   logic [1:0] grant_id;
   logic       busy;
   logic [0:0] slow_phase;
   logic       pending_any;
   logic [3:0] ovf;

   pulse_xfer_scheduler #(.N_REQ(4), .RATIO(R), .CNT_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .req_pulse   (req_pulse),
      .ovf_clr     (ovf_clr),
      .edge_out    (edge_out),
      .grant_id    (grant_id),
      .busy        (busy),
      .slow_phase  (slow_phase),
      .pending_any (pending_any),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int id;
      int rise;   // expected cycle of the rising edge, -1 = not checked
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int id, input int rise);
      exp_t e;
      e.id   = id;
      e.rise = rise;
      q.push_back(e);
   endtask

   // Monitor
   initial begin : monitor
      int   hi_len;
      int   last_fall;
      logic prev_edge;
      exp_t e;
      hi_len    = 0;
      last_fall = -100;
      prev_edge = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hi_len    = 0;
            prev_edge = 1'b0;
         end else begin
            if (edge_out && !prev_edge) begin
               chk("busy_with_edge", {31'd0, busy}, 1);
               chk("gap_width_ok", {31'd0, (cyc - last_fall) >= R}, 1);
               if (q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_edge: grant_id %0d at cycle %0d, no transfer expected",
                           grant_id, cyc);
               end else begin
                  e = q.pop_front();
                  chk("grant_id", {30'd0, grant_id}, e.id);
                  if (e.rise >= 0) chk("rise_cycle", cyc, e.rise);
               end
            end
            if (edge_out) begin
               hi_len++;
            end else if (prev_edge) begin
               chk("high_width", hi_len, R);
               hi_len    = 0;
               last_fall = cyc;
            end
            prev_edge = edge_out;
         end
      end
   end

   task automatic wait_phase(input logic [0:0] p);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (slow_phase == p) return;
      end
      n_chk++;
      n_fail++;
      $display("FAIL wait_phase: phase %0d not seen, last %0d", p, slow_phase);
   endtask

   task automatic wait_quiet(input string name);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!busy && !pending_any && q.size() == 0) return;
      end
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout, busy %0d pending %0d, %0d transfers outstanding",
               name, busy, pending_any, q.size());
      q.delete();
   endtask

   task automatic pulse(input logic [3:0] m);
      req_pulse = m;
      @(negedge clk);
      req_pulse = '0;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int c0;
      rst       = 1'b1;
      en        = 1'b0;
      req_pulse = '0;
      ovf_clr   = '0;
      #12;
      chk("rst_edge_out", {31'd0, edge_out}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_grant_id", {30'd0, grant_id}, 0);
      chk("rst_phase", {31'd0, slow_phase}, 0);
      chk("rst_pending", {31'd0, pending_any}, 0);
      chk("rst_ovf", {28'd0, ovf}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("phase_step", {31'd0, slow_phase}, 1);
      @(negedge clk);
      chk("phase_wrap", {31'd0, slow_phase}, 0);

      // Fairness: one pulse on every requester, pointer starts at 0
      en = 1'b1;
      wait_phase(1);
      c0 = cyc;
      push(0, c0 + 3);
      push(1, c0 + 7);
      push(2, c0 + 11);
      push(3, c0 + 15);
      pulse(4'b1111);
      while (cyc < c0 + 11) @(negedge clk);
      chk("pending_before_last", {31'd0, pending_any}, 1);
      while (cyc < c0 + 15) @(negedge clk);
      chk("pending_after_last", {31'd0, pending_any}, 0);
      wait_quiet("fairness");

      // Single pulse latency
      wait_phase(1);
      c0 = cyc;
      push(0, c0 + 3);
      pulse(4'b0001);
      wait_quiet("single");
      chk("grant_hold_idle", {30'd0, grant_id}, 0);

      // Saturation with en=0, then drain
      en = 1'b0;
      for (int k = 0; k < 5; k++) pulse(4'b0100);
      @(negedge clk);
      chk("sat_ovf", {28'd0, ovf}, 4'b0100);
      chk("sat_pending", {31'd0, pending_any}, 1);
      chk("sat_no_busy", {31'd0, busy}, 0);
      push(2, -1);
      push(2, -1);
      push(2, -1);
      en = 1'b1;
      wait_quiet("saturation");
      chk("ovf_sticky", {28'd0, ovf}, 4'b0100);
      ovf_clr = 4'b0100;
      @(negedge clk);
      ovf_clr = '0;
      chk("ovf_cleared", {28'd0, ovf}, 0);

      // Pulse in the requester's own grant cycle keeps its count
      en = 1'b0;
      pulse(4'b0010);
      wait_phase(1);
      en = 1'b1;
      c0 = cyc;
      push(1, c0 + 1);
      push(1, c0 + 5);
      pulse(4'b0010);
      wait_quiet("simultaneous");

      // en dropped in the second ISSUE cycle
      en = 1'b0;
      pulse(4'b1100);
      wait_phase(1);
      en = 1'b1;
      c0 = cyc;
      push(2, c0 + 1);
      @(negedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (20) @(negedge clk);
      chk("en_low_outstanding", q.size(), 0);
      chk("en_low_pending", {31'd0, pending_any}, 1);
      chk("en_low_idle", {31'd0, busy}, 0);
      push(3, -1);
      en = 1'b1;
      wait_quiet("en_drop");

      // Asynchronous reset in the middle of ISSUE
      en = 1'b0;
      pulse(4'b0110);
      wait_phase(1);
      en = 1'b1;
      c0 = cyc;
      push(1, c0 + 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_edge_out", {31'd0, edge_out}, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_pending", {31'd0, pending_any}, 0);
      chk("arst_grant_id", {30'd0, grant_id}, 0);
      chk("arst_phase", {31'd0, slow_phase}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_phase(1);
      c0 = cyc;
      push(3, c0 + 3);
      pulse(4'b1000);
      wait_quiet("after_reset");

      chk("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
